// File: rtl/dtpu_pkg.sv
// Shared types and constants for the DTPU: FSM state encoding, CSR byte map,
// and the width of one result lane.
package dtpu_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RD_CSR   = 4'd1,
        S_LD_W     = 4'd2,
        S_WAIT_IN  = 4'd3,
        S_COMPUTE  = 4'd4,
        S_WAIT_OUT = 4'd5,
        S_WR_STAT  = 4'd6,
        S_DONE     = 4'd7
    } state_t;

    localparam logic [31:0] CSR_ADDR_CFG    = 32'd0;
    localparam logic [31:0] CSR_ADDR_STATUS = 32'd2;

    localparam int LANE_W = 16;

endpackage

// File: rtl/dtpu_mxu.sv
// Combinational ROWS x COLUMNS signed multiply-accumulate array.
// Each column sum is sign-extended into its own LANE_W lane; spare lanes are zero.
module dtpu_mxu
    import dtpu_pkg::*;
#(
    parameter int DW      = 4,
    parameter int ROWS    = 3,
    parameter int COLUMNS = 3,
    parameter int OUT_W   = 64
) (
    input  logic [ROWS-1:0][DW-1:0]              x,
    input  logic [ROWS-1:0][COLUMNS-1:0][DW-1:0] w,
    output logic [OUT_W-1:0]                     y
);

    for (genvar c = 0; c < COLUMNS; c++) begin : g_col
        logic signed [LANE_W-1:0] acc;

        // Operands are widened to the lane width before multiplying, so the
        // product and sum are exact as long as they fit a lane.
        always_comb begin
            acc = '0;
            for (int r = 0; r < ROWS; r++) begin
                acc = acc + LANE_W'($signed(x[r])) * LANE_W'($signed(w[r][c]));
            end
        end

        assign y[c*LANE_W +: LANE_W] = acc;
    end

    if (COLUMNS*LANE_W < OUT_W) begin : g_pad
        assign y[OUT_W-1:COLUMNS*LANE_W] = '0;
    end

endmodule

// File: rtl/dtpu_core.sv
// Weight-stationary matrix unit: reads a job config from CSR, loads a weight
// tile, streams one matrix-vector product per input word, writes status back.
module dtpu_core
    import dtpu_pkg::*;
#(
    parameter int DATA_WIDTH_MAC      = 4,
    parameter int ROWS                = 3,
    parameter int COLUMNS             = 3,
    parameter int SIZE_WMEMORY        = 8196,
    parameter int SIZE_CSR            = 1024,
    parameter int DATA_WIDTH_CSR      = 8,
    parameter int DATA_WIDTH_WMEMORY  = 64,
    parameter int DATA_WIDTH_FIFO_IN  = 64,
    parameter int DATA_WIDTH_FIFO_OUT = 64
) (
    input  logic                           clk,
    input  logic                           aresetn,
    input  logic                           enable,
    output logic                           test_mode,
    output logic [31:0]                    csr_address,
    output logic                           csr_clk,
    output logic [DATA_WIDTH_CSR-1:0]      csr_din,
    input  logic [DATA_WIDTH_CSR-1:0]      csr_dout,
    output logic                           csr_ce,
    output logic                           csr_reset,
    output logic                           csr_we,
    output logic [31:0]                    wm_address,
    output logic                           wm_clk,
    output logic [DATA_WIDTH_WMEMORY-1:0]  wm_din,
    input  logic [DATA_WIDTH_WMEMORY-1:0]  wm_dout,
    output logic                           wm_ce,
    output logic                           wm_reset,
    output logic                           wm_we,
    input  logic                           infifo_is_empty,
    input  logic [DATA_WIDTH_FIFO_IN-1:0]  infifo_dout,
    output logic                           infifo_read,
    input  logic                           outfifo_is_full,
    output logic [DATA_WIDTH_FIFO_OUT-1:0] outfifo_din,
    output logic                           outfifo_write,
    input  logic                           cs_start,
    input  logic                           cs_continue,
    output logic                           cs_done,
    output logic                           cs_idle,
    output logic                           cs_ready,
    output logic [3:0]                     state
);

    localparam int DW     = DATA_WIDTH_MAC;
    localparam int STEP_W = $clog2(ROWS + 2);

    state_t cur_st, nxt_st;

    logic [STEP_W-1:0]                     step;
    logic [6:0]                            n_vec;
    logic [6:0]                            count;
    logic                                  test_mode_q;
    logic [ROWS-1:0][COLUMNS-1:0][DW-1:0]  w;
    logic [ROWS-1:0][DW-1:0]               x;
    logic [DATA_WIDTH_FIFO_OUT-1:0]        result;
    logic [DATA_WIDTH_FIFO_OUT-1:0]        mxu_y;

    assign csr_clk   = clk;
    assign wm_clk    = clk;
    assign csr_reset = ~aresetn;
    assign wm_reset  = ~aresetn;
    assign wm_din    = '0;
    assign wm_we     = 1'b0;

    assign state       = cur_st;
    assign test_mode   = test_mode_q;
    assign outfifo_din = result;
    assign cs_idle     = (cur_st == S_IDLE);
    assign cs_ready    = (cur_st == S_IDLE);
    assign cs_done     = (cur_st == S_DONE);

    // Upper data bits beyond the tile are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{infifo_dout, wm_dout};

    dtpu_mxu #(
        .DW      (DW),
        .ROWS    (ROWS),
        .COLUMNS (COLUMNS),
        .OUT_W   (DATA_WIDTH_FIFO_OUT)
    ) u_mxu (
        .x (x),
        .w (w),
        .y (mxu_y)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) cur_st <= S_IDLE;
        else          cur_st <= nxt_st;
    end

    always_comb begin
        nxt_st        = cur_st;
        csr_ce        = 1'b0;
        csr_we        = 1'b0;
        csr_address   = CSR_ADDR_CFG;
        csr_din       = '0;
        wm_ce         = 1'b0;
        wm_address    = '0;
        infifo_read   = 1'b0;
        outfifo_write = 1'b0;

        case (cur_st)
            S_IDLE:     if (cs_start) nxt_st = S_RD_CSR;
            S_RD_CSR: begin
                csr_ce = (step == '0);
                if (step == STEP_W'(1))
                    nxt_st = (csr_dout[6:0] == '0) ? S_WR_STAT : S_LD_W;
            end
            S_LD_W: begin
                // Address stays visible while paused so the fetch point is observable.
                wm_address = 32'(step);
                wm_ce      = (step < STEP_W'(ROWS));
                if (step == STEP_W'(ROWS)) nxt_st = S_WAIT_IN;
            end
            S_WAIT_IN: begin
                infifo_read = !infifo_is_empty;
                if (!infifo_is_empty) nxt_st = S_COMPUTE;
            end
            S_COMPUTE:  nxt_st = S_WAIT_OUT;
            S_WAIT_OUT: begin
                outfifo_write = !outfifo_is_full;
                if (!outfifo_is_full)
                    nxt_st = (count + 7'd1 == n_vec) ? S_WR_STAT : S_WAIT_IN;
            end
            S_WR_STAT: begin
                csr_ce      = 1'b1;
                csr_we      = 1'b1;
                csr_address = CSR_ADDR_STATUS;
                csr_din     = {1'b1, count};
                nxt_st      = S_DONE;
            end
            S_DONE:     if (cs_continue) nxt_st = S_IDLE;
            default:    nxt_st = S_IDLE;
        endcase

        if (!enable) begin
            nxt_st        = cur_st;
            csr_ce        = 1'b0;
            csr_we        = 1'b0;
            wm_ce         = 1'b0;
            infifo_read   = 1'b0;
            outfifo_write = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            step        <= '0;
            n_vec       <= '0;
            count       <= '0;
            test_mode_q <= 1'b0;
            w           <= '0;
            x           <= '0;
            result      <= '0;
        end else if (enable) begin
            case (cur_st)
                S_IDLE: if (cs_start) begin
                    count <= '0;
                    step  <= '0;
                end
                S_RD_CSR: begin
                    if (step == '0) begin
                        step <= STEP_W'(1);
                    end else begin
                        n_vec       <= csr_dout[6:0];
                        test_mode_q <= csr_dout[7];
                        step        <= '0;
                    end
                end
                S_LD_W: begin
                    // Row r arrives one cycle after its address was issued.
                    for (int r = 0; r < ROWS; r++) begin
                        if (step == STEP_W'(r + 1))
                            w[r] <= wm_dout[COLUMNS*DW-1:0];
                    end
                    step <= step + STEP_W'(1);
                end
                S_WAIT_IN:  if (!infifo_is_empty) x <= infifo_dout[ROWS*DW-1:0];
                S_COMPUTE:  result <= mxu_y;
                S_WAIT_OUT: if (!outfifo_is_full) count <= count + 7'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dtpu_core.sv
// Directed bench for dtpu_core: reset, basic job, stalls, multi-vector, N=0,
// pause and mid-job reset, each compared against hand-computed values.
module tb_dtpu_core;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic        test_mode;
    logic [31:0] csr_address;
    logic        csr_clk;
    logic [7:0]  csr_din;
    logic [7:0]  csr_dout;
    logic        csr_ce;
    logic        csr_reset;
    logic        csr_we;
    logic [31:0] wm_address;
    logic        wm_clk;
    logic [63:0] wm_din;
    logic [63:0] wm_dout;
    logic        wm_ce;
    logic        wm_reset;
    logic        wm_we;
    logic        infifo_is_empty;
    logic [63:0] infifo_dout;
    logic        infifo_read;
    logic        outfifo_is_full;
    logic [63:0] outfifo_din;
    logic        outfifo_write;
    logic        cs_start;
    logic        cs_continue;
    logic        cs_done;
    logic        cs_idle;
    logic        cs_ready;
    logic [3:0]  state;

    int tests = 0;
    int fails = 0;

    int          rd_n = 0;
    int          wr_n = 0;
    int          csrw_n = 0;
    int          both_n = 0;
    logic [31:0] last_csr_addr = '0;
    logic [7:0]  last_csr_data = '0;
    logic [63:0] last_out = '0;

    always #5 clk = ~clk;

    dtpu_core dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .enable          (enable),
        .test_mode       (test_mode),
        .csr_address     (csr_address),
        .csr_clk         (csr_clk),
        .csr_din         (csr_din),
        .csr_dout        (csr_dout),
        .csr_ce          (csr_ce),
        .csr_reset       (csr_reset),
        .csr_we          (csr_we),
        .wm_address      (wm_address),
        .wm_clk          (wm_clk),
        .wm_din          (wm_din),
        .wm_dout         (wm_dout),
        .wm_ce           (wm_ce),
        .wm_reset        (wm_reset),
        .wm_we           (wm_we),
        .infifo_is_empty (infifo_is_empty),
        .infifo_dout     (infifo_dout),
        .infifo_read     (infifo_read),
        .outfifo_is_full (outfifo_is_full),
        .outfifo_din     (outfifo_din),
        .outfifo_write   (outfifo_write),
        .cs_start        (cs_start),
        .cs_continue     (cs_continue),
        .cs_done         (cs_done),
        .cs_idle         (cs_idle),
        .cs_ready        (cs_ready),
        .state           (state)
    );

    always @(posedge clk) begin
        if (infifo_read) rd_n++;
        if (outfifo_write) begin
            wr_n++;
            last_out = outfifo_din;
        end
        if (infifo_read && outfifo_write) both_n++;
        if (csr_ce && csr_we) begin
            csrw_n++;
            last_csr_addr = csr_address;
            last_csr_data = csr_din;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_st(input logic [3:0] s, input int maxc, input string tag);
        int k = 0;
        while (state !== s && k < maxc) begin
            cyc();
            k++;
        end
        check(tag, {60'd0, state}, {60'd0, s});
    endtask

    task automatic finish_job(input string tag);
        cs_continue = 1'b1;
        cyc();
        cs_continue = 1'b0;
        check(tag, {60'd0, state}, 64'd0);
    endtask

    int rd0, wr0, cw0;

    initial begin
        aresetn = 1'b0; enable = 1'b0; csr_dout = '0; wm_dout = '0;
        infifo_is_empty = 1'b1; infifo_dout = '0; outfifo_is_full = 1'b0;
        cs_start = 1'b0; cs_continue = 1'b0;

        // Reset and idle
        cyc(); cyc();
        check("rst_state", {60'd0, state}, 64'd0);
        check("rst_idle", {62'd0, cs_idle, cs_ready}, 64'd3);
        check("rst_strobes", {59'd0, csr_ce, csr_we, wm_ce, infifo_read, outfifo_write}, 64'd0);
        check("rst_mirror", {62'd0, csr_reset, wm_reset}, 64'd3);
        aresetn = 1'b1; enable = 1'b1;
        repeat (7) cyc();
        check("idle_hold", {60'd0, state}, 64'd0);
        check("idle_mirror", {62'd0, csr_reset, wm_reset}, 64'd0);

        // Basic job: w=-1, x=(-2,-1,-6) -> lanes 9
        csr_dout = 8'h01; wm_dout = '1; infifo_dout = 64'hCAFECAFECAFECAFE; infifo_is_empty = 1'b0;
        rd0 = rd_n; wr0 = wr_n; cw0 = csrw_n;
        cs_start = 1'b1;
        cyc();
        cs_start = 1'b0;
        check("rdcsr_c1", {30'd0, state, csr_ce, csr_address}, {30'd0, 4'd1, 1'b1, 32'd0});
        cyc();
        check("rdcsr_c2", {59'd0, state, csr_ce}, {59'd0, 4'd1, 1'b0});
        cyc();
        check("ldw_a0", {30'd0, state, wm_ce, wm_address}, {30'd0, 4'd2, 1'b1, 32'd0});
        wait_st(4'd7, 50, "basic_done_state");
        check("basic_reads", 64'(rd_n - rd0), 64'd1);
        check("basic_writes", 64'(wr_n - wr0), 64'd1);
        check("basic_result", last_out, 64'h0000_0009_0009_0009);
        check("basic_csrw", 64'(csrw_n - cw0), 64'd1);
        check("basic_status", {24'd0, last_csr_addr, last_csr_data}, {24'd0, 32'd2, 8'h81});
        check("basic_done", {62'd0, cs_done, cs_ready}, 64'd2);
        finish_job("basic_idle");

        // Stalls on empty input and full output
        infifo_is_empty = 1'b1; outfifo_is_full = 1'b1;
        rd0 = rd_n; wr0 = wr_n;
        cs_start = 1'b1;
        cyc();
        cs_start = 1'b0;
        wait_st(4'd3, 20, "stall_reach_in");
        repeat (5) cyc();
        check("stall_in_hold", {60'd0, state}, 64'd3);
        check("stall_in_noread", 64'(rd_n - rd0), 64'd0);
        infifo_is_empty = 1'b0;
        #1;
        check("stall_in_release", {63'd0, infifo_read}, 64'd1);
        cyc();
        infifo_is_empty = 1'b1;
        check("stall_compute", {60'd0, state}, 64'd4);
        cyc();
        repeat (5) cyc();
        check("stall_out_hold", {60'd0, state}, 64'd5);
        check("stall_out_nowrite", 64'(wr_n - wr0), 64'd0);
        outfifo_is_full = 1'b0;
        #1;
        check("stall_out_release", {63'd0, outfifo_write}, 64'd1);
        cyc();
        check("stall_wrstat", {59'd0, state, csr_we}, {59'd0, 4'd6, 1'b1});
        wait_st(4'd7, 10, "stall_done");
        check("stall_counts", {32'(rd_n - rd0), 32'(wr_n - wr0)}, {32'd1, 32'd1});
        finish_job("stall_idle");

        // Three vectors, w=1, x=(1,2,3) -> lanes 6
        csr_dout = 8'h03; wm_dout = 64'h1111_1111_1111_1111; infifo_dout = 64'h321; infifo_is_empty = 1'b0;
        wr0 = wr_n;
        cs_start = 1'b1;
        cyc();
        cs_start = 1'b0;
        wait_st(4'd7, 100, "multi_done");
        check("multi_writes", 64'(wr_n - wr0), 64'd3);
        check("multi_result", last_out, 64'h0000_0006_0006_0006);
        check("multi_status", {56'd0, last_csr_data}, 64'h83);
        check("multi_tmode", {63'd0, test_mode}, 64'd0);
        finish_job("multi_idle");

        // N=0 with test_mode set
        csr_dout = 8'h80;
        rd0 = rd_n; wr0 = wr_n;
        cs_start = 1'b1;
        cyc();
        cs_start = 1'b0;
        wait_st(4'd7, 20, "n0_done_state");
        check("n0_fifo", {32'(rd_n - rd0), 32'(wr_n - wr0)}, 64'd0);
        check("n0_tmode", {62'd0, test_mode, cs_done}, 64'd3);
        check("n0_status", {24'd0, last_csr_addr, last_csr_data}, {24'd0, 32'd2, 8'h80});
        finish_job("n0_idle");

        // Pause during weight load, then reset during output wait
        csr_dout = 8'h01; infifo_is_empty = 1'b0; outfifo_is_full = 1'b1;
        cs_start = 1'b1;
        cyc();
        cs_start = 1'b0;
        cyc(); cyc(); cyc();
        check("pause_pre", {27'd0, state, wm_ce, wm_address}, {27'd0, 4'd2, 1'b1, 32'd1});
        enable = 1'b0;
        #1;
        check("pause_noce", {63'd0, wm_ce}, 64'd0);
        repeat (3) cyc();
        check("pause_frozen", {28'd0, state, wm_address}, {28'd0, 4'd2, 32'd1});
        enable = 1'b1;
        wait_st(4'd5, 20, "midrst_reach_out");
        aresetn = 1'b0;
        #1;
        check("midrst_state", {60'd0, state}, 64'd0);
        check("midrst_strobes", {58'd0, csr_ce, csr_we, wm_ce, infifo_read, outfifo_write, cs_done}, 64'd0);
        check("midrst_data", {outfifo_din}, 64'd0);
        check("midrst_addr", {csr_address, wm_address}, 64'd0);
        check("midrst_tmode", {56'd0, csr_din[6:0], test_mode}, 64'd0);
        cyc();
        aresetn = 1'b1;
        cyc();

        check("pulse_rule", 64'(both_n), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
